// File: rtl/srm_controller.sv
// srm_controller: Moore control FSM for the simple RISC machine datapath.
// Instructions are fetched, decoded from opcode/op, and then sequenced
// through operand fetch, execute, memory and write-back steps.
// Optional build macro: SRM_HALT_EN (opcode 111 enters a sticky HALT state).
module srm_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       load_pc,
   output logic       clear_pc,
   output logic       load_ir,
   output logic       load_addr,
   output logic       sel_addr,
   output logic       ram_w_en,
   output logic [1:0] reg_sel,
   output logic [1:0] wb_sel,
   output logic       w_en,
   output logic       en_A,
   output logic       en_B,
   output logic       en_C,
   output logic       en_status,
   output logic       sel_A,
   output logic       sel_B,
   output logic       halted
);

   typedef enum logic [4:0] {
      S_RESET, S_FETCH, S_LOAD_IR, S_UPDATE_PC, S_DECODE, S_WRITE_IMM,
      S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG, S_MEM_ADDR, S_MEM_RD,
      S_LDR_WB, S_GET_D, S_PASS_D, S_MEM_WR, S_HALT
   } state_t;

   state_t state_q, state_d;

   logic is_movi_s, is_movr_s, is_alu_s, is_cmp_s, is_mvn_s;
   logic is_ldr_s, is_str_s, is_mem_s, is_halt_s;

   assign is_movi_s = (opcode == 3'b110) && (op == 2'b10);
   assign is_movr_s = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu_s  = (opcode == 3'b101);
   assign is_cmp_s  = is_alu_s && (op == 2'b01);
   assign is_mvn_s  = is_alu_s && (op == 2'b11);
   assign is_ldr_s  = (opcode == 3'b011) && (op == 2'b00);
   assign is_str_s  = (opcode == 3'b100) && (op == 2'b00);
   assign is_mem_s  = is_ldr_s || is_str_s;
`ifdef SRM_HALT_EN
   assign is_halt_s = (opcode == 3'b111);
`else
   assign is_halt_s = 1'b0;
`endif

   // State register; reset forces RESET immediately from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing for each instruction class.
   always_comb begin
      state_d = S_RESET;
      case (state_q)
         S_RESET:     state_d = S_FETCH;
         S_FETCH:     state_d = S_LOAD_IR;
         S_LOAD_IR:   state_d = S_UPDATE_PC;
         S_UPDATE_PC: state_d = S_DECODE;
         S_DECODE: begin
            if (is_movi_s) begin
               state_d = S_WRITE_IMM;
            end else if (is_movr_s) begin
               state_d = S_GET_B;
            end else if (is_alu_s || is_mem_s) begin
               state_d = S_GET_A;
            end else if (is_halt_s) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;   // unrecognised: PC already advanced
            end
         end
         S_GET_A: begin
            if (is_mem_s) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_GET_B;
            end
         end
         S_GET_B:     state_d = S_EXEC;
         S_EXEC: begin
            if (is_cmp_s) begin
               state_d = S_FETCH;
            end else if (is_mem_s) begin
               state_d = S_MEM_ADDR;
            end else begin
               state_d = S_WRITE_REG;
            end
         end
         S_MEM_ADDR: begin
            if (is_ldr_s) begin
               state_d = S_MEM_RD;
            end else begin
               state_d = S_GET_D;
            end
         end
         S_MEM_RD:    state_d = S_LDR_WB;
         S_GET_D:     state_d = S_PASS_D;
         S_PASS_D:    state_d = S_MEM_WR;
         S_WRITE_IMM: state_d = S_FETCH;
         S_WRITE_REG: state_d = S_FETCH;
         S_LDR_WB:    state_d = S_FETCH;
         S_MEM_WR:    state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;  // left only through rst_n
         default:     state_d = S_RESET;
      endcase
   end

   // Moore output decode; anything not named for a state stays 0.
   always_comb begin
      load_pc   = 1'b0;
      clear_pc  = 1'b0;
      load_ir   = 1'b0;
      load_addr = 1'b0;
      sel_addr  = 1'b0;
      ram_w_en  = 1'b0;
      reg_sel   = 2'd0;
      wb_sel    = 2'd0;
      w_en      = 1'b0;
      en_A      = 1'b0;
      en_B      = 1'b0;
      en_C      = 1'b0;
      en_status = 1'b0;
      sel_A     = 1'b0;
      sel_B     = 1'b0;
      halted    = 1'b0;
      case (state_q)
         S_RESET:     begin clear_pc = 1'b1; load_pc = 1'b1; end
         S_FETCH:     sel_addr = 1'b1;
         S_LOAD_IR:   begin sel_addr = 1'b1; load_ir = 1'b1; end
         S_UPDATE_PC: load_pc = 1'b1;
         S_WRITE_IMM: begin reg_sel = 2'd0; wb_sel = 2'd1; w_en = 1'b1; end
         S_GET_A:     begin reg_sel = 2'd0; en_A = 1'b1; end
         S_GET_B:     begin reg_sel = 2'd2; en_B = 1'b1; end
         S_EXEC: begin
            en_C      = 1'b1;
            sel_A     = is_movr_s || is_mvn_s;
            sel_B     = is_mem_s;
            en_status = is_cmp_s;
         end
         S_WRITE_REG: begin reg_sel = 2'd1; wb_sel = 2'd0; w_en = 1'b1; end
         S_MEM_ADDR:  load_addr = 1'b1;
         S_LDR_WB:    begin reg_sel = 2'd1; wb_sel = 2'd2; w_en = 1'b1; end
         S_GET_D:     begin reg_sel = 2'd1; en_B = 1'b1; end
         S_PASS_D:    begin sel_A = 1'b1; en_C = 1'b1; end
         S_MEM_WR:    ram_w_en = 1'b1;
`ifdef SRM_HALT_EN
         S_HALT:      halted = 1'b1;
`endif
         default:     halted = 1'b0;   // DECODE, MEM_RD: no outputs
      endcase
   end

endmodule

// File: tb/tb_srm_controller.sv
// tb_srm_controller: directed plus random instruction stream checked
// cycle by cycle against a step-list model of each instruction class.
module tb_srm_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] opcode;
   logic [1:0] op;
   logic load_pc, clear_pc, load_ir, load_addr, sel_addr, ram_w_en;
   logic [1:0] reg_sel, wb_sel;
   logic w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, halted;
   logic [17:0] obs;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   srm_controller dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .op(op),
      .load_pc(load_pc), .clear_pc(clear_pc), .load_ir(load_ir),
      .load_addr(load_addr), .sel_addr(sel_addr), .ram_w_en(ram_w_en),
      .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A),
      .en_B(en_B), .en_C(en_C), .en_status(en_status), .sel_A(sel_A),
      .sel_B(sel_B), .halted(halted)
   );

   always #5 clk = ~clk;

   // Packed view of all outputs:
   // 17 load_pc 16 clear_pc 15 load_ir 14 load_addr 13 sel_addr 12 ram_w_en
   // 11:10 reg_sel 9:8 wb_sel 7 w_en 6 en_A 5 en_B 4 en_C 3 en_status
   // 2 sel_A 1 sel_B 0 halted
   assign obs = {load_pc, clear_pc, load_ir, load_addr, sel_addr, ram_w_en,
                 reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
                 sel_A, sel_B, halted};

   localparam logic [17:0] O_RESET  = 18'h30000;
   localparam logic [17:0] O_FETCH  = 18'h02000;
   localparam logic [17:0] O_LOADIR = 18'h0A000;
   localparam logic [17:0] O_UPDPC  = 18'h20000;
   localparam logic [17:0] O_NONE   = 18'h00000;
   localparam logic [17:0] O_WIMM   = 18'h00180;
   localparam logic [17:0] O_GETA   = 18'h00040;
   localparam logic [17:0] O_GETB   = 18'h00820;
   localparam logic [17:0] O_EXEC   = 18'h00010;
   localparam logic [17:0] F_STATUS = 18'h00008;
   localparam logic [17:0] F_SELA   = 18'h00004;
   localparam logic [17:0] F_SELB   = 18'h00002;
   localparam logic [17:0] O_WREG   = 18'h00480;
   localparam logic [17:0] O_MADDR  = 18'h04000;
   localparam logic [17:0] O_LDRWB  = 18'h00680;
   localparam logic [17:0] O_GETD   = 18'h00420;
   localparam logic [17:0] O_PASSD  = 18'h00014;
   localparam logic [17:0] O_MEMWR  = 18'h01000;
   localparam logic [17:0] O_HALT   = 18'h00001;

   task automatic check_vec(input string tag, input logic [17:0] got,
                            input logic [17:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Assert reset (called near a negedge), check async response, hold, release.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_vec("reset_async", obs, O_RESET);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check_vec("reset_hold", obs, O_RESET);
      end
      rst_n = 1'b1;
   endtask

   // Run one instruction from FETCH entry; abort_at >= 0 pulls reset after
   // that cycle index has been checked.
   task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                            input int abort_at);
      logic [17:0] q[$];
      logic [17:0] ex;
      int exp_w, exp_r, n_w, n_r, n_both;
      bit aborted, halts;
      q = '{O_FETCH, O_LOADIR, O_UPDPC, O_NONE};
      exp_w = 0; exp_r = 0; halts = 1'b0; aborted = 1'b0;
      if (opc == 3'b110 && o == 2'b10) begin
         q.push_back(O_WIMM); exp_w = 1;
      end else if (opc == 3'b110 && o == 2'b00) begin
         q.push_back(O_GETB); q.push_back(O_EXEC | F_SELA);
         q.push_back(O_WREG); exp_w = 1;
      end else if (opc == 3'b101) begin
         ex = O_EXEC;
         if (o == 2'b01) ex = ex | F_STATUS;
         if (o == 2'b11) ex = ex | F_SELA;
         q.push_back(O_GETA); q.push_back(O_GETB); q.push_back(ex);
         if (o != 2'b01) begin q.push_back(O_WREG); exp_w = 1; end
      end else if (opc == 3'b011 && o == 2'b00) begin
         q.push_back(O_GETA); q.push_back(O_EXEC | F_SELB);
         q.push_back(O_MADDR); q.push_back(O_NONE); q.push_back(O_LDRWB);
         exp_w = 1;
      end else if (opc == 3'b100 && o == 2'b00) begin
         q.push_back(O_GETA); q.push_back(O_EXEC | F_SELB);
         q.push_back(O_MADDR); q.push_back(O_GETD); q.push_back(O_PASSD);
         q.push_back(O_MEMWR); exp_r = 1;
      end
`ifdef SRM_HALT_EN
      else if (opc == 3'b111) begin
         halts = 1'b1;
         for (int i = 0; i < 20; i++) q.push_back(O_HALT);
      end
`endif
      n_w = 0; n_r = 0; n_both = 0;
      for (int i = 0; i < q.size(); i++) begin
         @(posedge clk);
         if (i == 0) begin
            #1;
            opcode = opc;
            op     = o;
         end
         @(negedge clk);
         check_vec($sformatf("op%0b_%0b_cyc%0d", opc, o, i), obs, q[i]);
         if (w_en === 1'b1) n_w++;
         if (ram_w_en === 1'b1) n_r++;
         if (w_en === 1'b1 && ram_w_en === 1'b1) n_both++;
         if (i == abort_at) begin
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         check_int("abort_no_write", n_w, 0);
         do_reset();
      end else begin
         check_int("w_en_count", n_w, exp_w);
         check_int("ram_w_en_count", n_r, exp_r);
         check_int("write_overlap", n_both, 0);
         if (halts) do_reset();
      end
   endtask

   logic [4:0] legal_enc [7] = '{5'b11010, 5'b11000, 5'b10100, 5'b10101,
                                 5'b10111, 5'b01100, 5'b10000};

   initial begin
      logic [4:0] enc;
      rst_n  = 1'b0;
      opcode = 3'b000;
      op     = 2'b00;
      @(negedge clk);
      check_vec("reset_state", obs, O_RESET);
      do_reset();

      run_instr(3'b110, 2'b10, -1);   // MOV imm
      run_instr(3'b101, 2'b00, -1);   // ADD
      run_instr(3'b101, 2'b01, -1);   // CMP
      run_instr(3'b100, 2'b00, -1);   // STR
      run_instr(3'b011, 2'b00, -1);   // LDR
      run_instr(3'b011, 2'b00, 7);    // LDR, reset during MEM_RD
      run_instr(3'b110, 2'b00, -1);   // MOV reg
      run_instr(3'b101, 2'b11, -1);   // MVN
      run_instr(3'b101, 2'b10, -1);   // AND
      run_instr(3'b111, 2'b01, -1);   // HALT or ignored
      run_instr(3'b000, 2'b00, -1);   // unrecognised

      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            enc = legal_enc[$urandom_range(0, 6)];
         end else begin
            enc = 5'($urandom_range(0, 31));
         end
         run_instr(enc[4:2], enc[1:0], -1);
      end

      @(posedge clk);
      @(negedge clk);
      check_vec("final_fetch", obs, O_FETCH);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/srm_controller.md
SRM_CONTROLLER -- requirements
Module: srm_controller

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have opcode  input  3  instruction bits [15:13] from instruction register.
REQ-005 SHALL have op  input  2  instruction bits [12:11] from instruction register.
REQ-006 SHALL have load_pc, clear_pc  output  1 each  PC load enable; PC source = start_pc when clear_pc else PC+1.
REQ-007 SHALL have load_ir, load_addr  output  1 each  instruction register load; data address register load from C[8:0].
REQ-008 SHALL have sel_addr  output  1  memory address = PC when 1, data address register when 0.
REQ-009 SHALL have ram_w_en  output  1  data memory write enable.
REQ-010 SHALL have reg_sel  output  2  register file index select: 0 Rn, 1 Rd, 2 Rm.
REQ-011 SHALL have wb_sel  output  2  write-back source: 0 datapath C, 1 sximm8, 2 memory read data.
REQ-012 SHALL have w_en, en_A, en_B, en_C, en_status  output  1 each  datapath load enables.
REQ-013 SHALL have sel_A, sel_B  output  1 each  A operand forced to 0; B operand = sximm5.
REQ-014 SHALL have halted  output  1  high only in HALT state.

Function
REQ-015 SHALL be a Moore FSM; all outputs decoded from state plus opcode/op; every output not listed for a state is 0.
REQ-016 SHALL implement states and outputs: RESET (clear_pc, load_pc); FETCH (sel_addr); LOAD_IR (sel_addr, load_ir); UPDATE_PC (load_pc); DECODE (none); WRITE_IMM (reg_sel=0, wb_sel=1, w_en); GET_A (reg_sel=0, en_A); GET_B (reg_sel=2, en_B); EXEC (en_C); WRITE_REG (reg_sel=1, wb_sel=0, w_en); MEM_ADDR (load_addr); MEM_RD (sel_addr=0); LDR_WB (reg_sel=1, wb_sel=2, w_en); GET_D (reg_sel=1, en_B); PASS_D (sel_A, en_C); MEM_WR (ram_w_en); HALT (halted).
REQ-017 SHALL sequence RESET->FETCH->LOAD_IR->UPDATE_PC->DECODE unconditionally, one cycle each.
REQ-018 SHALL decode in DECODE: 110/10 MOV imm->WRITE_IMM; 110/00 MOV reg->GET_B; 101/xx ALU->GET_A; 011/00 LDR and 100/00 STR->GET_A; any other encoding->FETCH (ignored, PC already advanced).
REQ-019 SHALL go GET_A->EXEC for LDR/STR, GET_A->GET_B for ALU, GET_B->EXEC.
REQ-020 SHALL in EXEC assert sel_A for MOV reg and MVN (101/11), sel_B for LDR/STR, en_status for CMP (101/01) only.
REQ-021 SHALL go EXEC->FETCH for CMP, EXEC->MEM_ADDR for LDR/STR, else EXEC->WRITE_REG; WRITE_IMM, WRITE_REG, LDR_WB, MEM_WR -> FETCH.
REQ-022 SHALL go MEM_ADDR->MEM_RD->LDR_WB for LDR; MEM_ADDR->GET_D->PASS_D->MEM_WR for STR.
REQ-023 SHALL give per-instruction latency from FETCH entry to next FETCH: MOV imm 5, MOV reg 7, CMP 7, ADD/AND/MVN 8, LDR 9, STR 10 cycles.
REQ-024 SHALL assert w_en and ram_w_en in at most one cycle per instruction, never together.

Reset
REQ-025 SHALL enter RESET asynchronously on rst_n low, from any state including mid-instruction; no w_en/ram_w_en pulse on reset entry.
REQ-026 SHALL hold RESET outputs (clear_pc=1, load_pc=1, all else 0) while rst_n low; first edge after release moves to FETCH.

Configuration
REQ-027 SHALL, with SRM_HALT_EN defined, decode opcode 111 (any op) in DECODE to HALT; HALT is held until rst_n low, halted=1, all enables 0.
REQ-028 SHALL, without SRM_HALT_EN, treat opcode 111 as an unrecognised encoding (DECODE->FETCH) and tie halted to 0.

Verification
REQ-029 SHALL cover: reset release, opcode=110 op=10 -> RESET,FETCH,LOAD_IR,UPDATE_PC,DECODE,WRITE_IMM; w_en=1, wb_sel=1 on cycle 5 only.
REQ-030 SHALL cover: opcode=101 op=00 (ADD) -> GET_A,GET_B,EXEC,WRITE_REG; reg_sel 0,2,x,1; 8 cycles FETCH-to-FETCH.
REQ-031 SHALL cover: opcode=101 op=01 (CMP) -> en_status=1 in EXEC, w_en never asserted, back to FETCH after 7 cycles.
REQ-032 SHALL cover: opcode=100 op=00 (STR) -> sel_B=1 in EXEC, load_addr, GET_D, PASS_D with sel_A=1, ram_w_en=1 with sel_addr=0 on cycle 10.
REQ-033 SHALL cover: rst_n low during LDR MEM_RD -> immediate RESET, clear_pc=1, no LDR_WB write.
REQ-034 SHALL cover: opcode=111 -> HALT with halted=1 for 20 cycles (SRM_HALT_EN), or FETCH after DECODE (undefined).
